// File: rtl/uart_tx_engine.sv
// UART transmitter: 8 data bits sent LSB first, optional even/odd parity,
// and 1 or 2 stop bits. The bit period is a fixed number of clk cycles.
//
// Handshake (tx_start / tx_ready): a byte is accepted on a rising clk edge
// where tx_start=1 and tx_ready=1, which is only possible in IDLE.
// tx_data is sampled on that edge only. tx_ready is registered: it drops on
// the acceptance edge and stays low for the whole frame. It rises again on
// the terminal count of the last stop bit, so it is high for at least one
// idle cycle between frames.
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic [3:0] busy_bit
);

    localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam bit              PAR_EN    = (PARITY == 1) || (PARITY == 2);
    localparam bit              PAR_ODD   = (PARITY == 2);
    // Index of the final stop bit; any STOP_BITS value other than 2 means one.
    localparam logic [2:0]      STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             par_bit, par_bit_n;
    logic             tx_n;
    logic             tx_ready_n;
    logic             baud_done;

    assign baud_done = (baud_cnt == CNT_LAST);

    // State and datapath registers; reset forces the line idle at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            par_bit  <= par_bit_n;
            tx       <= tx_n;
            tx_ready <= tx_ready_n;
        end
    end

    // Next-state logic. tx is computed here and registered, so the line is
    // never combinationally driven by the inputs.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        par_bit_n  = par_bit;
        tx_n       = tx;
        tx_ready_n = tx_ready;

        if (state == IDLE) begin
            tx_n       = 1'b1;
            tx_ready_n = 1'b1;
            if (tx_start) begin
                // Start bit goes out on the acceptance edge itself.
                shreg_n    = tx_data;
                par_bit_n  = (^tx_data) ^ PAR_ODD;
                state_n    = START;
                tx_n       = 1'b0;
                tx_ready_n = 1'b0;
                baud_cnt_n = '0;
                bit_idx_n  = '0;
            end
        end else if (!baud_done) begin
            baud_cnt_n = baud_cnt + CNT_W'(1);
        end else begin
            // Terminal count: restart the counter and drive the next bit now.
            baud_cnt_n = '0;
            case (state)
                START: begin
                    state_n   = DATA;
                    tx_n      = shreg[0];
                    bit_idx_n = 3'd0;
                end
                DATA: begin
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = 3'd0;
                        if (PAR_EN) begin
                            state_n = PAR;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
                PAR: begin
                    state_n   = STOP;
                    tx_n      = 1'b1;
                    bit_idx_n = 3'd0;
                end
                STOP: begin
                    tx_n = 1'b1;
                    if (bit_idx == STOP_LAST) begin
                        state_n    = IDLE;
                        tx_ready_n = 1'b1;
                        bit_idx_n  = 3'd0;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
                default: begin
                    state_n    = IDLE;
                    tx_n       = 1'b1;
                    tx_ready_n = 1'b1;
                end
            endcase
        end
    end

    // Debug index of the frame bit currently on the line (15 when idle).
    always_comb begin
        busy_bit = 4'd15;
        case (state)
            IDLE:    busy_bit = 4'd15;
            START:   busy_bit = 4'd0;
            DATA:    busy_bit = {1'b0, bit_idx} + 4'd1;
            PAR:     busy_bit = 4'd9;
            STOP:    busy_bit = {1'b0, bit_idx} + 4'd10;
            default: busy_bit = 4'd15;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine. Four instances cover the parameter
// corners: 4 clk/bit with no parity, even parity, odd parity with two stop
// bits, and 2 clk/bit.
module tb_uart_tx_engine;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic [3:0] start_v;
    logic [7:0] data_v [4];
    logic [3:0] tx_v;
    logic [3:0] rdy_v;
    logic [3:0] busy_v [4];

    int checks = 0;
    int errors = 0;

    // Scoreboard: one entry per frame bit, {busy_bit, tx level}.
    logic [4:0] exp_q[$];

    uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rstn(rstn), .tx_start(start_v[0]), .tx_data(data_v[0]),
        .tx_ready(rdy_v[0]), .tx(tx_v[0]), .busy_bit(busy_v[0]));
    uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .rstn(rstn), .tx_start(start_v[1]), .tx_data(data_v[1]),
        .tx_ready(rdy_v[1]), .tx(tx_v[1]), .busy_bit(busy_v[1]));
    uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) dut_c (
        .clk(clk), .rstn(rstn), .tx_start(start_v[2]), .tx_data(data_v[2]),
        .tx_ready(rdy_v[2]), .tx(tx_v[2]), .busy_bit(busy_v[2]));
    uart_tx_engine #(.CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1)) dut_d (
        .clk(clk), .rstn(rstn), .tx_start(start_v[3]), .tx_data(data_v[3]),
        .tx_ready(rdy_v[3]), .tx(tx_v[3]), .busy_bit(busy_v[3]));

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check($sformatf("%s_tx_d%0d", tag, d), int'(tx_v[d]), 1);
        check($sformatf("%s_rdy_d%0d", tag, d), int'(rdy_v[d]), 1);
        check($sformatf("%s_busy_d%0d", tag, d), int'(busy_v[d]), 15);
    endtask

    // Sends one byte and checks tx, tx_ready and busy_bit on every cycle of
    // the frame, then the idle state on the cycle tx_ready comes back.
    // drop_start releases tx_start once tx_ready is seen low; corrupt writes
    // 0xFF to tx_data in the middle of the frame.
    task automatic send_frame(input int d, input logic [7:0] data, input int clks,
                              input int pmode, input int stops,
                              input bit drop_start, input bit corrupt);
        logic [4:0] e;
        int cyc;
        check($sformatf("ready_before_d%0d", d), int'(rdy_v[d]), 1);
        exp_q.delete();
        exp_q.push_back({4'd0, 1'b0});
        for (int i = 0; i < 8; i++) exp_q.push_back({4'(i + 1), data[i]});
        if (pmode == 1 || pmode == 2) exp_q.push_back({4'd9, (^data) ^ (pmode == 2)});
        for (int j = 0; j < stops; j++) exp_q.push_back({4'(10 + j), 1'b1});
        start_v[d] = 1'b1;
        data_v[d]  = data;
        step();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int c = 0; c < clks; c++) begin
                check($sformatf("tx_d%0d_%02h_c%0d", d, data, cyc), int'(tx_v[d]), int'(e[0]));
                check($sformatf("rdy_d%0d_%02h_c%0d", d, data, cyc), int'(rdy_v[d]), 0);
                check($sformatf("busy_d%0d_%02h_c%0d", d, data, cyc), int'(busy_v[d]), int'(e[4:1]));
                if (drop_start && cyc == 0) start_v[d] = 1'b0;
                if (corrupt && cyc == 3 * clks) data_v[d] = 8'hFF;
                cyc++;
                step();
            end
        end
        check_idle(d, $sformatf("end_%02h", data));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn    = 1'b0;
        start_v = '0;
        for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check_idle(i, "reset");
        rstn = 1'b1;
        step();

        // 0x55, parser-style handshake; then no second frame appears.
        send_frame(0, 8'h55, 4, 0, 1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle(0, "no_refire");
        end

        // Parity modes and two stop bits.
        send_frame(1, 8'h07, 4, 1, 1, 1'b1, 1'b0);
        send_frame(2, 8'h07, 4, 2, 2, 1'b1, 1'b0);
        send_frame(1, 8'h3A, 4, 1, 1, 1'b1, 1'b0);
        send_frame(2, 8'hC4, 4, 2, 2, 1'b1, 1'b0);

        // Back-to-back with tx_start held; mid-frame data change is ignored.
        send_frame(0, 8'hA5, 4, 0, 1, 1'b0, 1'b1);
        send_frame(0, 8'h3C, 4, 0, 1, 1'b1, 1'b0);

        // Reset during DATA bit 3, no clock edge needed for it to act.
        start_v[0] = 1'b1;
        data_v[0]  = 8'h55;
        step();
        start_v[0] = 1'b0;
        repeat (17) step();
        check("pre_reset_busy", int'(busy_v[0]), 4);
        #2 rstn = 1'b0;
        #1;
        check_idle(0, "async_reset");
        @(negedge clk);
        rstn = 1'b1;
        step();
        check_idle(0, "after_reset");
        send_frame(0, 8'h81, 4, 0, 1, 1'b1, 1'b0);

        // Two clocks per bit.
        send_frame(3, 8'h00, 2, 0, 1, 1'b1, 1'b0);
        send_frame(3, 8'hFF, 2, 0, 1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serial UART transmitter for the command parser's TX path.
- Accepts one byte at a time through the parser's tx_start / tx_data / tx_ready handshake and drives the FPGA board's UART TX pin.
- Frame format: 8 data bits, LSB first, with an optional parity bit and 1 or 2 stop bits.
- Bit timing comes from a fixed clock-divider parameter; there is no FIFO, and the parser is the only source of bytes.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200). Legal range 2..65535.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd. Value 3 behaves as 0.
- STOP_BITS, 1, number of stop bits: 1 or 2. Any other value behaves as 1.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous reset, active-low.
- tx_start  in  1  byte-valid request from the parser; level-sensitive.
- tx_data  in  8  byte to send; sampled only on the acceptance cycle.
- tx_ready  out  1  high when idle and able to accept a byte.
- tx  out  1  serial line; idles high. Registered output with no combinational path from inputs.
- busy_bit  out  4  debug index of the current frame bit: 0 start, 1-8 data, 9 parity, 10-11 stop. Value 15 when idle. Intended for the board LEDs.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, tx_ready=1, busy_bit=15, state=IDLE.
  - Baud counter and bit index cleared; shift register cleared to 0.
- States: IDLE, START, DATA, PAR, STOP.
- Acceptance:
  - In IDLE, tx_start=1 sampled on rising edge k accepts the byte.
  - At edge k: shift register <= tx_data; parity bit computed and latched from tx_data; state <= START; tx <= 0; tx_ready <= 0; baud counter <= 0.
  - Latency from the acceptance edge to the start bit on tx is 0 cycles: tx is low in the cycle after edge k.
- Bit timing:
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1. At terminal count it resets to 0 and the next bit is driven on that same edge.
- Transitions:
  - START to DATA: tx = shreg[0].
  - DATA shifts right once per bit for 8 bits, with the bit index running 0..7.
  - After bit 7, DATA goes to PAR if PARITY is 1 or 2, otherwise to STOP.
  - Parity bit: even mode drives XOR of the 8 data bits; odd mode drives its inverse.
  - STOP drives tx=1 for STOP_BITS × CLKS_PER_BIT cycles.
  - At terminal count of the last stop bit: state <= IDLE, tx_ready <= 1.
- Frame length, from the acceptance edge to tx_ready re-asserting: CLKS_PER_BIT × (1 + 8 + P + S) cycles, where P is 0 or 1 and S = STOP_BITS.
- Handshake:
  - tx_ready falls the cycle after acceptance and stays low for the whole frame.
  - tx_start and tx_data are ignored while tx_ready=0, including any changes to tx_data mid-frame.
  - The parser keeps tx_start high until it sees tx_ready=0; this must not cause a second acceptance.
- Back-to-back frames:
  - tx_ready is high for at least one cycle in IDLE between frames.
  - If tx_start=1 during that cycle, the next frame is accepted at that edge.
  - The gap between the last stop bit and the next start bit is therefore exactly 1 clk cycle, with tx=1.
- Simultaneous events: tx_start arriving on the same edge as the last stop bit's terminal count is not accepted. Acceptance happens on the following edge, from IDLE.
- Reset mid-frame: tx returns high immediately, tx_ready=1, and the partial frame is dropped. No resume after reset.
- Width rules:
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - Bit index is 3 bits.
  - busy_bit is derived from state and bit index.

Test Plan:
- CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, send 0x55 -> tx shows start 0, then data 1,0,1,0,1,0,1,0, then stop 1, each bit for 4 cycles. tx_ready is low for exactly 40 cycles after the acceptance edge.
- Parser-style handshake: hold tx_start=1 until tx_ready=0, then drop it -> exactly one frame is sent and tx_ready returns to 1.
- PARITY=1, send 0x07 -> parity bit = 1. PARITY=2, send 0x07 -> parity bit = 0. STOP_BITS=2 -> stop high for 8 cycles with CLKS_PER_BIT=4, and the frame is 48 cycles.
- Back-to-back: tx_start held high continuously with 0xA5 then 0x3C -> two correct frames separated by exactly 1 idle-high cycle. Changing tx_data to 0xFF mid-frame does not alter the 0xA5 frame.
- Reset asserted during DATA bit 3 -> tx=1 and tx_ready=1 immediately with no clock edge needed. After release, sending 0x81 produces a clean full frame.
- CLKS_PER_BIT=2 corner case, send 0x00 and 0xFF -> correct 20-cycle frames, and busy_bit sequences 0..8, 10, then 15.
